fetch_control: RTL
==================

FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter INT_VECTOR, default 32'h0000_0000: PC loaded on interrupt entry.
REQ-002 Parameter MAX_WAIT, default 7: resolve-wait watchdog limit in cycles (4-bit counter).
REQ-003 One clock; reset is synchronous and active-high (i_clk, i_reset).
REQ-004 i_clk  in  1  rising-edge clock.
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 i_hazard_instruction  in  1  fetched instruction is call/ret/rti/jz/jn/jc/jmp/ldm.
REQ-007 i_interrupt  in  1  external interrupt request, level, sampled each cycle.
REQ-008 i_pc_inc  in  32  fetch PC output: next PC, or held PC during an interrupt.
REQ-009 i_data_stall  in  1  decode load-use stall.
REQ-010 i_resolve_valid  in  1  execute resolved the pending hazard instruction this cycle.
REQ-011 i_resolve_taken  in  1  resolved instruction redirects PC.
REQ-012 i_resolve_target  in  32  redirect target.
REQ-013 i_flags  in  4  CCR flags to save on interrupt.
REQ-014 o_enable  out  1  fetch PC register enable.
REQ-015 o_insert_nop  out  1  fetch replaces its instruction with 16'h0000.
REQ-016 o_pc_new  out  32  redirect PC.
REQ-017 o_branch_decision  out  1  fetch selects o_pc_new.
REQ-018 o_int_push  out  1  memory stage pushes o_int_data onto the stack.
REQ-019 o_int_data  out  32  value to push.
REQ-020 o_error  out  1  one-cycle pulse on watchdog expiry.
REQ-021 o_busy  out  1  state other than RUN.

Function
REQ-022 States: RUN, WAIT_RESOLVE, INT_PUSH_PC, INT_PUSH_FLAGS, INT_JUMP; outputs are decoded combinationally from state and resolve inputs.
REQ-023 RUN outputs: o_enable = !i_data_stall; o_insert_nop = 0; o_branch_decision = 0; o_int_push = 0.
REQ-024 RUN with i_interrupt, or pending flag set: latch ret_pc = i_pc_inc, clear pending, go to INT_PUSH_PC. Interrupt has priority over a hazard instruction in the same cycle.
REQ-025 RUN with i_hazard_instruction and !i_data_stall and no interrupt: the instruction passes, the watchdog counter clears, and the FSM goes to WAIT_RESOLVE.
REQ-026 RUN with i_data_stall: state holds and the hazard is not accepted until the stall drops.
REQ-027 WAIT_RESOLVE: o_enable = 0; o_insert_nop = 1; the counter increments each cycle.
REQ-028 WAIT_RESOLVE with i_resolve_valid and taken: in the same cycle, o_branch_decision = 1, o_pc_new = i_resolve_target, o_enable = 1, o_insert_nop = 1; next state RUN.
REQ-029 WAIT_RESOLVE with i_resolve_valid and not taken: o_enable = 1, o_insert_nop = 1; next state RUN.
REQ-030 WAIT_RESOLVE with counter == MAX_WAIT and no resolve: pulse o_error, o_enable = 1, next state RUN. Resolve in the same cycle wins and o_error stays 0.
REQ-031 i_interrupt during WAIT_RESOLVE or any INT_* state: set the pending flag. It is serviced in RUN after resolve, and only one pending interrupt is held.
REQ-032 INT_PUSH_PC: o_int_push = 1, o_int_data = ret_pc, o_enable = 0, o_insert_nop = 1.
REQ-033 INT_PUSH_FLAGS: o_int_push = 1, o_int_data = {28'b0, i_flags}, o_enable = 0, o_insert_nop = 1.
REQ-034 INT_JUMP: o_branch_decision = 1, o_pc_new = INT_VECTOR, o_enable = 1, o_insert_nop = 1; next state RUN.
REQ-035 Interrupt entry takes exactly 3 cycles with no fetch advance before INT_JUMP.
REQ-036 o_pc_new = 0 whenever o_branch_decision = 0; o_int_data = 0 whenever o_int_push = 0.
REQ-037 o_busy = 1 in every state except RUN.

Reset
REQ-038 i_reset high at a rising edge: state goes to RUN, and the counter, pending flag and ret_pc clear, mid-sequence included.
REQ-039 While i_reset is high all outputs are forced: o_enable 0, o_insert_nop 1, o_branch_decision 0, o_pc_new 0, o_int_push 0, o_int_data 0, o_error 0, o_busy 0.

Structure
REQ-040 A shared package holds the state encoding (3-bit), opcode constants of the hazard set, and the default INT_VECTOR.
REQ-041 The watchdog counter is one sub-module, wait_counter (clear, increment, terminal-count compare against MAX_WAIT).

Verification
REQ-042 jmp: hazard=1 at cycle 0, resolve taken with target 32'h40 at cycle 2 -> nop asserted cycles 1-2, o_branch_decision=1 with o_pc_new=32'h40 at cycle 2, RUN at cycle 3.
REQ-043 jz not taken: resolve_valid=1, taken=0 at cycle 1 -> o_enable=1, o_branch_decision=0, o_busy low next cycle.
REQ-044 Interrupt with i_pc_inc=32'h12 and i_flags=4'b1010 -> pushes 32'h12 then 32'h0000000A, then o_pc_new=INT_VECTOR, over 3 cycles.
REQ-045 Interrupt during WAIT_RESOLVE -> serviced immediately after resolve, and ret_pc equals the post-redirect i_pc_inc.
REQ-046 No resolve for 7 cycles -> o_error pulses exactly once, and the FSM is back in RUN.
REQ-047 Reset asserted in INT_PUSH_FLAGS -> next cycle shows RUN, o_int_push=0, pending cleared.

Source files
------------

// File: rtl/fetch_control_pkg.sv
// Shared types and constants for the fetch control FSM.
package fetch_control_pkg;

  typedef enum logic [2:0] {
    ST_RUN            = 3'd0,
    ST_WAIT_RESOLVE   = 3'd1,
    ST_INT_PUSH_PC    = 3'd2,
    ST_INT_PUSH_FLAGS = 3'd3,
    ST_INT_JUMP       = 3'd4
  } state_t;

  localparam int          CNT_W          = 4;
  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0000;

  // Opcodes whose outcome is only known once execute resolves them.
  localparam logic [4:0] OP_CALL = 5'h10;
  localparam logic [4:0] OP_RET  = 5'h11;
  localparam logic [4:0] OP_RTI  = 5'h12;
  localparam logic [4:0] OP_JZ   = 5'h13;
  localparam logic [4:0] OP_JN   = 5'h14;
  localparam logic [4:0] OP_JC   = 5'h15;
  localparam logic [4:0] OP_JMP  = 5'h16;
  localparam logic [4:0] OP_LDM  = 5'h17;

  function automatic logic is_hazard_op(input logic [4:0] op);
    return op inside {OP_CALL, OP_RET, OP_RTI, OP_JZ, OP_JN, OP_JC, OP_JMP, OP_LDM};
  endfunction

endpackage

// File: rtl/fetch_control_wait_counter.sv
// Resolve-wait watchdog: clear, increment, terminal count at MAX_WAIT.
module wait_counter
  import fetch_control_pkg::*;
#(
  parameter int MAX_WAIT = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (inc)     cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/fetch_control.sv
// Fetch control: stalls fetch behind unresolved control-flow instructions
// and sequences the 3-cycle interrupt entry (push PC, push flags, jump).
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR,
  parameter int          MAX_WAIT   = 7
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hazard_instruction,
  input  logic        i_interrupt,
  input  logic [31:0] i_pc_inc,
  input  logic        i_data_stall,
  input  logic        i_resolve_valid,
  input  logic        i_resolve_taken,
  input  logic [31:0] i_resolve_target,
  input  logic [3:0]  i_flags,
  output logic        o_enable,
  output logic        o_insert_nop,
  output logic [31:0] o_pc_new,
  output logic        o_branch_decision,
  output logic        o_int_push,
  output logic [31:0] o_int_data,
  output logic        o_error,
  output logic        o_busy
);

  state_t      state;
  logic        pending;
  logic [31:0] ret_pc;
  logic        int_go, hz_go, tc;

  assign int_go = (state == ST_RUN) && (i_interrupt || pending);
  assign hz_go  = (state == ST_RUN) && !int_go && i_hazard_instruction && !i_data_stall;

  wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_counter (
    .clk   (i_clk),
    .reset (i_reset),
    .clr   (hz_go),
    .inc   (state == ST_WAIT_RESOLVE),
    .tc    (tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_RUN;
      pending <= 1'b0;
      ret_pc  <= '0;
    end else begin
      // Interrupts arriving while busy are held (one deep) until back in RUN.
      if (state != ST_RUN && i_interrupt) pending <= 1'b1;
      case (state)
        ST_RUN: begin
          if (int_go) begin
            ret_pc  <= i_pc_inc;
            pending <= 1'b0;
            state   <= ST_INT_PUSH_PC;
          end else if (hz_go) begin
            state <= ST_WAIT_RESOLVE;
          end
        end
        ST_WAIT_RESOLVE:   if (i_resolve_valid || tc) state <= ST_RUN;
        ST_INT_PUSH_PC:    state <= ST_INT_PUSH_FLAGS;
        ST_INT_PUSH_FLAGS: state <= ST_INT_JUMP;
        ST_INT_JUMP:       state <= ST_RUN;
        default:           state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    o_enable          = 1'b0;
    o_insert_nop      = 1'b1;
    o_pc_new          = '0;
    o_branch_decision = 1'b0;
    o_int_push        = 1'b0;
    o_int_data        = '0;
    o_error           = 1'b0;
    o_busy            = 1'b0;
    if (!i_reset) begin
      o_busy = (state != ST_RUN);
      case (state)
        ST_RUN: begin
          o_enable     = !i_data_stall;
          o_insert_nop = 1'b0;
        end
        ST_WAIT_RESOLVE: begin
          if (i_resolve_valid) begin
            o_enable = 1'b1;
            if (i_resolve_taken) begin
              o_branch_decision = 1'b1;
              o_pc_new          = i_resolve_target;
            end
          end else if (tc) begin
            o_enable = 1'b1;
            o_error  = 1'b1;
          end
        end
        ST_INT_PUSH_PC: begin
          o_int_push = 1'b1;
          o_int_data = ret_pc;
        end
        ST_INT_PUSH_FLAGS: begin
          o_int_push = 1'b1;
          o_int_data = {28'b0, i_flags};
        end
        ST_INT_JUMP: begin
          o_enable          = 1'b1;
          o_branch_decision = 1'b1;
          o_pc_new          = INT_VECTOR;
        end
        default: ;
      endcase
    end
  end

endmodule
